// File: rtl/dff_pipe_n.sv
// dff_pipe_n: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Each stage has its own valid bit. The ready chain collapses bubbles, so a
// stalled output only blocks the stages that hold words behind it.
// Both ends use valid/ready handshakes. A synchronous flush clears every
// stage, and a registered occupancy count tracks the held words.
// Optional build macro: DFF_PIPE_PARITY_EN adds a per-stage even-parity bit
// and a sticky parity_err flag. When it is undefined, parity_err is tied to 0.
module dff_pipe_n #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             parity_err
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic             rdy_acc;
  logic             accept;
  logic             emit;
  logic [CW-1:0]    count_nxt;

  // Ready chain: a stage may advance when it is empty or when there is a
  // hole anywhere downstream of it (including a consumer that is ready).
  // Stage i is ready when out_ready is high or any stage j >= i is empty.
  // Building it as an OR-accumulation from the output side keeps the
  // logic free of combinational self-reference on rdy.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_acc = rdy_acc | ~vld[i];
      rdy[i]  = rdy_acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush & rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign emit      = vld[DEPTH-1] & out_ready;

  // Occupancy: plus one on accept, minus one on emit. Accept and emit on
  // the same edge leave the count unchanged.
  always_comb begin
    count_nxt = count;
    if (accept && !emit) begin
      count_nxt = count + 1'b1;
    end else if (!accept && emit) begin
      count_nxt = count - 1'b1;
    end
  end

  // Stage registers. Flush clears the valid bits and holds the data.
  // Otherwise each ready stage takes the word from the stage before it.
  // Stage 0 loads in_data only on an accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= accept;
        if (accept) begin
          data[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld[i]  <= vld[i-1];
          data[i] <= data[i-1];
        end
      end
    end
  end

  // Registered occupancy count. Flush empties the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;

  // Each parity bit moves with its word. It is set so that the word plus
  // its parity bit has even parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= '0;
    end else if (!flush) begin
      if (rdy[0] && accept) begin
        par[0] <= ^in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          par[i] <= par[i-1];
        end
      end
    end
  end

  // Recheck parity on every emit. The error stays set until flush or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (flush) begin
      parity_err <= 1'b0;
    end else if (emit && ((^out_data) != par[DEPTH-1])) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe_n.sv
// Self-checking bench for dff_pipe_n (WIDTH=4, DEPTH=3).
// A scoreboard queue receives each word when it is accepted. The word is
// popped and compared when the DUT emits it.
module tb_dff_pipe_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [1:0] count;
  logic       parity_err;

  logic [3:0] sb_q [$];
  int         mcnt;
  int         n_pass;
  int         n_total;

  dff_pipe_n #(.WIDTH(4), .DEPTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Advance one clock. Handshake signals are sampled on the falling edge,
  // ahead of the rising edge that acts on them. The task returns 1 ns after
  // that rising edge.
  task automatic step(output logic acc, output logic emt, output logic [3:0] od);
    @(negedge clk);
    acc = in_valid & in_ready;
    emt = out_valid & out_ready;
    od  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain(input string name);
    logic acc, emt;
    logic [3:0] od, exp;
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      step(acc, emt, od);
      k++;
      if (emt) begin
        exp = sb_q.pop_front();
        n_total++;
        if (od !== exp) $display("FAIL %s_drain_data got=%h exp=%h", name, od, exp);
        else n_pass++;
      end
      mcnt = mcnt + int'(acc) - int'(emt);
    end
    n_total++;
    if (sb_q.size() != 0) $display("FAIL %s_drain_timeout left=%0d exp=0", name, sb_q.size());
    else n_pass++;
    n_total++;
    if (int'(count) !== mcnt) $display("FAIL %s_drain_count got=%0d exp=%0d", name, count, mcnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic acc, emt;
    logic [3:0] od;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
    mcnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_total++; if (out_data !== 4'h0) $display("FAIL rst_out_data got=%h exp=0", out_data); else n_pass++;
      n_total++; if (count !== 2'd0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(acc, emt, od);
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_release_valid got=%b exp=0", out_valid); else n_pass++;
    end
    n_total++; if (count !== 2'd0) $display("FAIL rst_release_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (parity_err !== 1'b0) $display("FAIL rst_parity_err got=%b exp=0", parity_err); else n_pass++;
  endtask

  task automatic test_latency();
    logic acc, emt;
    logic [3:0] od, exp;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hA;
    step(acc, emt, od);
    n_total++; if (acc !== 1'b1) $display("FAIL lat_accept got=%b exp=1", acc); else n_pass++;
    sb_q.push_back(4'hA);
    in_valid = 1'b0;
    n_total++; if (count !== 2'd1 || out_valid !== 1'b0) $display("FAIL lat_e0 count=%0d valid=%b exp=1/0", count, out_valid); else n_pass++;
    step(acc, emt, od);
    n_total++; if (count !== 2'd1 || out_valid !== 1'b0) $display("FAIL lat_e1 count=%0d valid=%b exp=1/0", count, out_valid); else n_pass++;
    step(acc, emt, od);
    n_total++; if (count !== 2'd1 || out_valid !== 1'b1) $display("FAIL lat_e2 count=%0d valid=%b exp=1/1", count, out_valid); else n_pass++;
    n_total++; if (out_data !== 4'hA) $display("FAIL lat_e2_data got=%h exp=a", out_data); else n_pass++;
    step(acc, emt, od);
    n_total++; if (emt !== 1'b1) $display("FAIL lat_emit got=%b exp=1", emt); else n_pass++;
    if (emt && sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      n_total++; if (od !== exp) $display("FAIL lat_emit_data got=%h exp=%h", od, exp); else n_pass++;
    end
    n_total++; if (count !== 2'd0) $display("FAIL lat_count_after got=%0d exp=0", count); else n_pass++;
    mcnt = 0;
    sb_q.delete();
  endtask

  task automatic test_streaming();
    logic acc, emt;
    logic [3:0] od, exp;
    logic [3:0] v;
    int nemit, ndrain;
    out_ready = 1'b1;
    nemit = 0;
    for (int k = 1; k <= 20; k++) begin
      v = 4'(k);
      in_valid = 1'b1; in_data = v;
      step(acc, emt, od);
      n_total++; if (acc !== 1'b1) $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, acc); else n_pass++;
      if (acc) sb_q.push_back(v);
      if (emt) begin
        nemit++;
        exp = sb_q.pop_front();
        n_total++; if (od !== exp) $display("FAIL stream_data got=%h exp=%h", od, exp); else n_pass++;
      end
      mcnt = mcnt + int'(acc) - int'(emt);
    end
    n_total++; if (nemit !== 17) $display("FAIL stream_emit_count got=%0d exp=17", nemit); else n_pass++;
    in_valid = 1'b0;
    ndrain = 0;
    while (sb_q.size() != 0 && ndrain < 10) begin
      step(acc, emt, od);
      ndrain++;
      if (emt) begin
        exp = sb_q.pop_front();
        n_total++; if (od !== exp) $display("FAIL stream_tail_data got=%h exp=%h", od, exp); else n_pass++;
      end
      mcnt = mcnt + int'(acc) - int'(emt);
    end
    n_total++; if (ndrain !== 3) $display("FAIL stream_tail_cycles got=%0d exp=3", ndrain); else n_pass++;
    n_total++; if (count !== 2'd0) $display("FAIL stream_count_end got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic acc, emt;
    logic [3:0] od, exp;
    out_ready = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      in_valid = 1'b1; in_data = 4'(k);
      step(acc, emt, od);
      n_total++; if (acc !== 1'b1) $display("FAIL bp_fill_accept got=%b exp=1", acc); else n_pass++;
      if (acc) sb_q.push_back(4'(k));
      mcnt = mcnt + int'(acc) - int'(emt);
    end
    n_total++; if (count !== 2'd3) $display("FAIL bp_full_count got=%0d exp=3", count); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); else n_pass++;
    in_data = 4'h8;
    step(acc, emt, od);
    n_total++; if (acc !== 1'b0) $display("FAIL bp_stall_accept got=%b exp=0", acc); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_data !== 4'h5) $display("FAIL bp_hold got=%b/%h exp=1/5", out_valid, out_data); else n_pass++;
    n_total++; if (count !== 2'd3) $display("FAIL bp_stall_count got=%0d exp=3", count); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(acc, emt, od);
      if (k == 0) begin
        n_total++; if (acc !== 1'b1) $display("FAIL bp_fourth_accept got=%b exp=1", acc); else n_pass++;
        n_total++; if (count !== 2'd3) $display("FAIL bp_acc_emit_count got=%0d exp=3", count); else n_pass++;
        in_valid = 1'b0;
      end
      if (acc) sb_q.push_back(4'h8);
      n_total++; if (emt !== 1'b1) $display("FAIL bp_emit k=%0d got=%b exp=1", k, emt); else n_pass++;
      if (emt) begin
        exp = sb_q.pop_front();
        n_total++; if (od !== exp) $display("FAIL bp_emit_data got=%h exp=%h", od, exp); else n_pass++;
      end
      mcnt = mcnt + int'(acc) - int'(emt);
    end
    test_drain("bp");
  endtask

  task automatic test_flush();
    logic acc, emt;
    logic [3:0] od;
    out_ready = 1'b0;
    for (int k = 9; k <= 10; k++) begin
      in_valid = 1'b1; in_data = 4'(k);
      step(acc, emt, od);
      if (acc) sb_q.push_back(4'(k));
      mcnt = mcnt + int'(acc) - int'(emt);
    end
    n_total++; if (count !== 2'd2) $display("FAIL flush_pre_count got=%0d exp=2", count); else n_pass++;
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hB;
    step(acc, emt, od);
    n_total++; if (acc !== 1'b0) $display("FAIL flush_accept got=%b exp=0", acc); else n_pass++;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    mcnt = 0;
    n_total++; if (count !== 2'd0) $display("FAIL flush_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(acc, emt, od);
      n_total++; if (emt !== 1'b0) $display("FAIL flush_stale_emit got=%b exp=0", emt); else n_pass++;
    end
    n_total++; if (parity_err !== 1'b0) $display("FAIL flush_parity_err got=%b exp=0", parity_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic acc, emt;
    logic [3:0] od, exp, v;
    for (int k = 0; k < 300; k++) begin
      v = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = v;
      out_ready = ($urandom_range(0, 2) != 0);
      step(acc, emt, od);
      if (acc) sb_q.push_back(v);
      if (emt) begin
        n_total++;
        if (sb_q.size() == 0) $display("FAIL rand_unexpected_emit got=%h exp=none", od);
        else begin
          exp = sb_q.pop_front();
          if (od !== exp) $display("FAIL rand_data got=%h exp=%h", od, exp);
          else n_pass++;
        end
      end
      mcnt = mcnt + int'(acc) - int'(emt);
      n_total++; if (int'(count) !== mcnt) $display("FAIL rand_count got=%0d exp=%0d", count, mcnt); else n_pass++;
    end
    test_drain("rand");
    n_total++; if (parity_err !== 1'b0) $display("FAIL rand_parity_err got=%b exp=0", parity_err); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
